// File: rtl/ac_motor_pkg.sv
// ac_motor_pkg: shared definitions for the AC motor run/stop sequencer.
//   POWER_W        width of the power command
//   motor_state_e  sequencer states; encodings are visible on the debug state port
//   DEF_*          default timing and slew parameters
package ac_motor_pkg;

    localparam int unsigned POWER_W = 12;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArm      = 3'd1,
        StRamp     = 3'd2,
        StRun      = 3'd3,
        StRampDown = 3'd4,
        StDrain    = 3'd5,
        StFault    = 3'd6
    } motor_state_e;

    localparam int unsigned DEF_RAMP_DIV   = 1024;
    localparam int unsigned DEF_STEP       = 16;
    localparam int unsigned DEF_ARM_CYCLES = 256;
    localparam int unsigned DEF_OFF_CYCLES = 256;

endpackage

// File: rtl/ac_motor_ramp_tick.sv
// ac_motor_ramp_tick: ramp prescaler. Counts 0..RAMP_DIV-1 while run is high and
// flags tick in the cycle the count wraps.
//   clk   system clock
//   clear synchronous clear of the count (takes priority over run)
//   run   count enable
//   tick  one-cycle pulse on wrap
module ac_motor_ramp_tick
    import ac_motor_pkg::*;
#(
    parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
    input  logic clk,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Combinational from the registered count so the consumer can gate it by its
    // own next-state decision without forming a loop through clear.
    assign tick = run && (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ac_motor_sequencer.sv
// ac_motor_sequencer: run/stop sequencer for the three-phase PWM chain.
// Arms the switch-delay gates, slews power toward the target, drains at zero
// power before disarming, and latches external faults into a gate-off state.
//   clk, reset          clock and synchronous active-high reset
//   run_req             1 = run, 0 = controlled stop
//   target_power        desired power while running
//   fault, fault_clear  external fault level and its acknowledge
//   power               power command to motor control (registered)
//   enable              shared gate enable (registered)
//   at_speed            high in RUN (registered)
//   fault_latched       high in FAULT (registered)
//   state               current state encoding for debug
module ac_motor_sequencer
    import ac_motor_pkg::*;
#(
    parameter int unsigned RAMP_DIV   = DEF_RAMP_DIV,
    parameter int unsigned STEP       = DEF_STEP,
    parameter int unsigned ARM_CYCLES = DEF_ARM_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_req,
    input  logic [POWER_W-1:0] target_power,
    input  logic               fault,
    input  logic               fault_clear,
    output logic [POWER_W-1:0] power,
    output logic               enable,
    output logic               at_speed,
    output logic               fault_latched,
    output logic [2:0]         state
);

    localparam int unsigned DWELL_MAX = (ARM_CYCLES > OFF_CYCLES) ? ARM_CYCLES : OFF_CYCLES;
    localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);
    localparam logic [DWELL_W-1:0] ARM_LAST = DWELL_W'(ARM_CYCLES - 1);
    localparam logic [DWELL_W-1:0] OFF_LAST = DWELL_W'(OFF_CYCLES - 1);
    localparam logic [POWER_W:0]   STEP_X   = (POWER_W + 1)'(STEP);

    motor_state_e       state_q, state_d;
    logic [POWER_W-1:0] power_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               tick;
    logic [POWER_W:0]   up_sum, down_diff, tgt_x;
    logic [POWER_W-1:0] ramp_next, drop_next;

    assign state = state_q;

    // Prescaler restarts from zero on every state change, so the first step after
    // entering RAMP or RAMP_DOWN always comes a full RAMP_DIV cycles later.
    ac_motor_ramp_tick #(
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp_tick (
        .clk   (clk),
        .clear (reset || (state_d != state_q)),
        .run   ((state_q == StRamp) || (state_q == StRampDown)),
        .tick  (tick)
    );

    // One extra bit keeps the sum/difference from wrapping before the clamp.
    always_comb begin
        tgt_x     = {1'b0, target_power};
        up_sum    = {1'b0, power} + STEP_X;
        down_diff = {1'b0, power} - STEP_X;
        if (target_power > power) begin
            ramp_next = (up_sum >= tgt_x) ? target_power : up_sum[POWER_W-1:0];
        end else begin
            ramp_next = (down_diff[POWER_W] || (down_diff <= tgt_x)) ?
                        target_power : down_diff[POWER_W-1:0];
        end
        drop_next = down_diff[POWER_W] ? '0 : down_diff[POWER_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        power_d = power;
        if (fault) begin
            state_d = StFault;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run_req) state_d = StArm;
                end
                StArm: begin
                    if (!run_req)                state_d = StDrain;
                    else if (dwell_q == ARM_LAST) state_d = StRamp;
                end
                StRamp: begin
                    // A run_req drop wins over a coincident tick: no step is taken.
                    if (!run_req)                   state_d = StRampDown;
                    else if (power == target_power) state_d = StRun;
                    else if (tick)                  power_d = ramp_next;
                end
                StRun: begin
                    if (!run_req)                   state_d = StRampDown;
                    else if (power != target_power) state_d = StRamp;
                end
                StRampDown: begin
                    if (run_req)          state_d = StRamp;
                    else if (power == '0) state_d = StDrain;
                    else if (tick)        power_d = drop_next;
                end
                StDrain: begin
                    if (run_req)                  state_d = StRamp;
                    else if (dwell_q == OFF_LAST) state_d = StIdle;
                end
                StFault: begin
                    if (fault_clear && !run_req) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        if (!((state_d == StRamp) || (state_d == StRun) || (state_d == StRampDown))) begin
            power_d = '0;
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if ((state_q == StArm) || (state_q == StDrain)) begin
            dwell_d = dwell_q + DWELL_W'(1);
        end else begin
            dwell_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            power         <= '0;
            enable        <= 1'b0;
            at_speed      <= 1'b0;
            fault_latched <= 1'b0;
            dwell_q       <= '0;
        end else begin
            state_q       <= state_d;
            power         <= power_d;
            enable        <= (state_d != StIdle) && (state_d != StFault);
            at_speed      <= (state_d == StRun);
            fault_latched <= (state_d == StFault);
            dwell_q       <= dwell_d;
        end
    end

endmodule

// File: tb/tb_ac_motor_sequencer.sv
// tb_ac_motor_sequencer: directed bench for ac_motor_sequencer with RAMP_DIV=4,
// STEP=256, ARM_CYCLES=8, OFF_CYCLES=8. Stimulus queues the expected sequence of
// output tuples; a monitor pops one entry every time any output changes.
module tb_ac_motor_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RAMP = 3'd2, S_RUN = 3'd3;
    localparam logic [2:0] S_RDN = 3'd4, S_DRAIN = 3'd5, S_FAULT = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_req = 1'b0;
    logic [11:0] target_power = 12'h000;
    logic        fault = 1'b0;
    logic        fault_clear = 1'b0;
    logic [11:0] power;
    logic        enable, at_speed, fault_latched;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // gap = cycles since the previous output change; 0 means not checked.
    typedef struct {
        logic [17:0] tup;
        int          gap;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ac_motor_sequencer #(
        .RAMP_DIV   (4),
        .STEP       (256),
        .ARM_CYCLES (8),
        .OFF_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run_req       (run_req),
        .target_power  (target_power),
        .fault         (fault),
        .fault_clear   (fault_clear),
        .power         (power),
        .enable        (enable),
        .at_speed      (at_speed),
        .fault_latched (fault_latched),
        .state         (state)
    );

    task automatic push(input logic [2:0] st, input logic [11:0] pw, input logic en,
                        input logic at, input logic fl, input int gap);
        exp_t e;
        e.tup = {st, pw, en, at, fl};
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        @(posedge clk);
        #1;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state !== s) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, state=%0d required %0d", name, state, s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_power(input logic [11:0] p, input int budget, input string name);
        int n = 0;
        @(posedge clk);
        #1;
        while (power !== p && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (power !== p) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, power=%h required %h", name, power, p);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output change must match the next queued tuple.
    initial begin : monitor
        logic [17:0] cur, prev;
        int          cyc, last_cyc;
        bit          first;
        exp_t        e;
        cyc = 0;
        last_cyc = 0;
        first = 1'b1;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_on) begin
                cur = {state, power, enable, at_speed, fault_latched};
                if (first || cur !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: got st=%0d pw=%h en=%b at=%b fl=%b, none expected",
                                 cur[17:15], cur[14:3], cur[2], cur[1], cur[0]);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e.tup || (!first && e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
                            errors++;
                            $display("FAIL seq: got st=%0d pw=%h en=%b at=%b fl=%b gap=%0d, required st=%0d pw=%h en=%b at=%b fl=%b gap=%0d",
                                     cur[17:15], cur[14:3], cur[2], cur[1], cur[0], cyc - last_cyc,
                                     e.tup[17:15], e.tup[14:3], e.tup[2], e.tup[1], e.tup[0], e.gap);
                        end
                    end
                    prev = cur;
                    last_cyc = cyc;
                    first = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        cycles(3);
        reset = 1'b0;
        push(S_IDLE, 12'h000, 0, 0, 0, 0);
        mon_on = 1'b1;
        cycles(2);

        // Start to target 0x500.
        target_power = 12'h500;
        run_req = 1'b1;
        push(S_ARM, 12'h000, 1, 0, 0, 0);
        push(S_RAMP, 12'h000, 1, 0, 0, 8);
        for (int v = 12'h100; v <= 12'h500; v += 12'h100) push(S_RAMP, 12'(v), 1, 0, 0, 4);
        push(S_RUN, 12'h500, 1, 1, 0, 1);
        wait_state(S_RUN, 200, "start_to_run");

        // Downward clamp to 0x450.
        target_power = 12'h450;
        push(S_RAMP, 12'h500, 1, 0, 0, 0);
        push(S_RAMP, 12'h450, 1, 0, 0, 4);
        push(S_RUN, 12'h450, 1, 1, 0, 1);
        wait_state(S_RUN, 100, "clamp_down");

        // Upward to full scale without wrap.
        target_power = 12'hFFF;
        push(S_RAMP, 12'h450, 1, 0, 0, 0);
        for (int v = 12'h550; v <= 12'hF50; v += 12'h100) push(S_RAMP, 12'(v), 1, 0, 0, 4);
        push(S_RAMP, 12'hFFF, 1, 0, 0, 4);
        push(S_RUN, 12'hFFF, 1, 1, 0, 1);
        wait_state(S_RUN, 200, "clamp_up");

        // Back down to 0x400, ending on a clamped step.
        target_power = 12'h400;
        push(S_RAMP, 12'hFFF, 1, 0, 0, 0);
        for (int v = 12'hEFF; v >= 12'h4FF; v -= 12'h100) push(S_RAMP, 12'(v), 1, 0, 0, 4);
        push(S_RAMP, 12'h400, 1, 0, 0, 4);
        push(S_RUN, 12'h400, 1, 1, 0, 1);
        wait_state(S_RUN, 200, "down_to_400");

        // Reset mid-RUN.
        reset = 1'b1;
        push(S_IDLE, 12'h000, 0, 0, 0, 0);
        cycles(1);
        reset = 1'b0;
        run_req = 1'b0;
        cycles(3);

        // Run to 0x300, then controlled stop through DRAIN.
        target_power = 12'h300;
        run_req = 1'b1;
        push(S_ARM, 12'h000, 1, 0, 0, 0);
        push(S_RAMP, 12'h000, 1, 0, 0, 8);
        push(S_RAMP, 12'h100, 1, 0, 0, 4);
        push(S_RAMP, 12'h200, 1, 0, 0, 4);
        push(S_RAMP, 12'h300, 1, 0, 0, 4);
        push(S_RUN, 12'h300, 1, 1, 0, 1);
        wait_state(S_RUN, 100, "run_300");
        run_req = 1'b0;
        push(S_RDN, 12'h300, 1, 0, 0, 0);
        push(S_RDN, 12'h200, 1, 0, 0, 4);
        push(S_RDN, 12'h100, 1, 0, 0, 4);
        push(S_RDN, 12'h000, 1, 0, 0, 4);
        push(S_DRAIN, 12'h000, 1, 0, 0, 1);
        push(S_IDLE, 12'h000, 0, 0, 0, 8);
        wait_state(S_IDLE, 100, "stop_drain");
        cycles(2);

        // ARM aborted into DRAIN, restart from DRAIN cycle 3.
        run_req = 1'b1;
        push(S_ARM, 12'h000, 1, 0, 0, 0);
        wait_state(S_ARM, 20, "arm_again");
        run_req = 1'b0;
        push(S_DRAIN, 12'h000, 1, 0, 0, 0);
        wait_state(S_DRAIN, 20, "arm_abort");
        cycles(2);
        run_req = 1'b1;
        push(S_RAMP, 12'h000, 1, 0, 0, 0);
        push(S_RAMP, 12'h100, 1, 0, 0, 4);
        push(S_RAMP, 12'h200, 1, 0, 0, 4);
        wait_power(12'h200, 50, "restart_ramp");

        // One-cycle fault during RAMP at 0x200.
        fault = 1'b1;
        push(S_FAULT, 12'h000, 0, 0, 1, 0);
        cycles(1);
        fault = 1'b0;
        fault_clear = 1'b1;          // run_req still high: ignored
        cycles(1);
        fault_clear = 1'b0;
        cycles(2);
        run_req = 1'b0;
        fault = 1'b1;
        fault_clear = 1'b1;          // fault still present: ignored
        cycles(1);
        fault = 1'b0;
        cycles(1);                   // fault=0, clear=1, run_req=0 decides here
        push(S_IDLE, 12'h000, 0, 0, 0, 0);
        fault_clear = 1'b0;
        cycles(6);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected output changes never seen, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac_motor_sequencer.md
Name: ac_motor_sequencer

Overview:
- Run/stop sequencer for the three-phase PWM chain: control -> sine/triangle -> comparators -> switch delays.
- Drives the 12-bit `power` command into the motor control block and the shared `enable` into all three switch-delay gates.
- Arms the gates before torque is applied, ramps power up and down at a bounded slew rate, and drains before disarming.
- Latches external faults into an immediate, safe gate-off.

Parameters:
- RAMP_DIV, 1024: clock cycles between ramp ticks (>=1).
- STEP, 16: power increment or decrement applied per ramp tick (1..4095).
- ARM_CYCLES, 256: cycles `enable` is held high at power 0 before ramping starts (>=1).
- OFF_CYCLES, 256: cycles at power 0, gates still enabled, before `enable` drops (>=1).

Ports:
- clk, in, 1: system clock; all logic rising-edge.
- reset, in, 1: synchronous, active-high.
- run_req, in, 1: level. 1 = motor should run; 0 = controlled stop.
- target_power, in, 12: desired power while running; may change at any time.
- fault, in, 1: external fault, level. Highest priority.
- fault_clear, in, 1: acknowledge; single-cycle pulse or level.
- power, out, 12: power command to motor control.
- enable, out, 1: gate enable to all switch-delay instances.
- at_speed, out, 1: high when state is RUN.
- fault_latched, out, 1: high while in FAULT.
- state, out, 3: current state encoding, for debug.

Behaviour:
- All outputs are registered and change one cycle after the deciding condition.
- Reset (synchronous, any state) forces:
  - state = IDLE, power = 0, enable = 0, at_speed = 0, fault_latched = 0;
  - tick prescaler and dwell counter = 0.
- State encodings: IDLE=0, ARM=1, RAMP=2, RUN=3, RAMP_DOWN=4, DRAIN=5, FAULT=6.
- Fault priority: `fault`=1 in any non-reset state -> next cycle:
  - state FAULT, power 0, enable 0, fault_latched 1;
  - counters cleared. This overrides every other transition in the same cycle.
- IDLE: power 0, enable 0. run_req=1 and fault=0 -> ARM, with enable=1 from the next cycle.
- ARM: enable 1, power 0; the dwell counter counts ARM_CYCLES.
  - Counter expiry -> RAMP, prescaler reset.
  - run_req=0 during ARM -> DRAIN.
- Ramp tick: the prescaler counts 0..RAMP_DIV-1 and asserts a tick when it wraps. It runs only in RAMP and RAMP_DOWN, and is cleared on entry to either state.
- RAMP: on each tick, power moves toward target_power by STEP.
  - Use 13-bit arithmetic; clamp to target_power so there is no overshoot and no wrap.
  - power == target_power at a state evaluation -> RUN. This includes target 0 and entry with power already equal.
  - run_req=0 -> RAMP_DOWN.
- RUN: power held; at_speed=1.
  - target_power != power -> RAMP (at_speed drops next cycle).
  - run_req=0 -> RAMP_DOWN.
- RAMP_DOWN: on each tick, power -= STEP, clamped at 0.
  - power == 0 -> DRAIN.
  - run_req=1 -> RAMP; the ramp continues from the current power and is not re-armed.
- DRAIN: power 0, enable 1; the dwell counter counts OFF_CYCLES.
  - Expiry -> IDLE, with enable 0 next cycle.
  - run_req=1 during DRAIN -> RAMP; gates are still armed.
- FAULT: held while fault=1. Exit to IDLE only when fault=0, fault_clear=1 and run_req=0 in the same cycle; otherwise remain.
- Simultaneous events, in priority order:
  - reset > fault > run_req change > counter/tick events;
  - tick and run_req drop in the same cycle in RAMP: the step is not applied, go to RAMP_DOWN.
- `enable` is never high in IDLE or FAULT.
- `power` is never nonzero outside RAMP, RUN and RAMP_DOWN.
- `power` never changes by more than STEP per tick.

Decomposition:
- Shared package ac_motor_pkg:
  - POWER_W = 12;
  - the 3-bit state enum and its encodings;
  - default RAMP_DIV, STEP, ARM_CYCLES, OFF_CYCLES constants.
- One sub-module, ac_motor_ramp_tick: parameterised prescaler (RAMP_DIV), with clear and run inputs and a one-cycle tick output.
- FSM, clamped adder and dwell counter stay in ac_motor_sequencer.

Test Plan:
Bench parameters: RAMP_DIV=4, STEP=256, ARM_CYCLES=8, OFF_CYCLES=8.
1. Reset mid-RUN: power=0x400, run_req=1, assert reset for 1 cycle -> next cycle state=0, power=0, enable=0, at_speed=0.
2. Start to target: target=0x500, run_req 0->1.
   - enable=1 one cycle later.
   - power stays 0 for 8 cycles, then steps 0x100, 0x200, ..., 0x500, every 4 cycles.
   - State RUN and at_speed=1 once power=0x500.
3. Clamp and retarget in RUN: target=0x450 -> power steps 0x500 -> 0x450 in one tick (clamped), then RUN. Target=0xFFF -> steps of 0x100 up to 0xF50, then 0xFFF with no wrap.
4. Stop with drain: from RUN at 0x300, run_req=0.
   - Power 0x200, 0x100, 0x000 on ticks.
   - enable stays 1 for 8 cycles in DRAIN, then 0; state IDLE.
5. Fault: fault=1 for 1 cycle during RAMP at power 0x200 -> next cycle power=0, enable=0, fault_latched=1.
   - fault_clear with run_req=1 is ignored.
   - fault_clear with run_req=0 -> IDLE.
6. Restart during DRAIN: run_req=1 at DRAIN cycle 3 -> RAMP, power 0x100 after 4 cycles, enable never drops.
